// File: rtl/tdd_frame_sched.sv
// Frame-timing scheduler: counts samples into programmable-length frames and
// decodes TX/RX stream gating windows plus a frame sync pulse.
module tdd_frame_sched #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          tddmode,
    input  logic [CW-1:0] frame_len,
    input  logic [CW-1:0] frame_adj,
    input  logic          adj_req,
    input  logic [CW-1:0] tstart,
    input  logic [CW-1:0] tend,
    input  logic [CW-1:0] rstart,
    input  logic [CW-1:0] rend,
    output logic          ien,
    output logic          oen,
    output logic          sync,
    output logic [CW-1:0] fcnt,
    output logic [31:0]   frame_no,
    output logic          adj_pending,
    output logic          conflict
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int SW = CW + 2;
    localparam logic [CW-1:0]        ONE     = 1;
    localparam logic signed [SW-1:0] LEN_MIN = 2;
    localparam logic signed [SW-1:0] LEN_MAX = $signed({2'b00, {CW{1'b1}}});

    state_t        state_q, state_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [31:0]   frame_no_q, frame_no_d;
    logic          sync_q, sync_d;
    logic          ien_q, ien_d;
    logic          oen_q, oen_d;
    logic          conflict_q, conflict_d;
    logic          adj_pending_q, adj_pending_d;
    logic [CW-1:0] adj_val_q, adj_val_d;
    logic          tdd_q, tdd_d;
    logic [CW-1:0] tstart_q, tstart_d, tend_q, tend_d;
    logic [CW-1:0] rstart_q, rstart_d, rend_q, rend_d;

    logic                 frame_start;
    logic                 tx_hit, rx_hit;
    logic signed [SW-1:0] adj_ext, len_sum;

    function automatic logic win_hit(input logic [CW-1:0] s, input logic [CW-1:0] e,
                                     input logic [CW-1:0] c);
        if (s < e)
            return (c >= s) && (c < e);
        else if (s > e)
            return (c >= s) || (c < e);
        else
            return 1'b0;
    endfunction

    // Two extra bits so a large positive adjust on a near-max length still clamps
    // at the top instead of wrapping negative.
    assign adj_ext = adj_pending_q ? $signed({{2{adj_val_q[CW-1]}}, adj_val_q}) : '0;
    assign len_sum = $signed({2'b00, frame_len}) + adj_ext;

    always_comb begin
        state_d       = state_q;
        fcnt_d        = '0;
        frame_no_d    = '0;
        sync_d        = 1'b0;
        ien_d         = 1'b0;
        oen_d         = 1'b0;
        len_d         = len_q;
        conflict_d    = conflict_q;
        adj_pending_d = adj_pending_q;
        adj_val_d     = adj_val_q;
        tdd_d         = tdd_q;
        tstart_d      = tstart_q;
        tend_d        = tend_q;
        rstart_d      = rstart_q;
        rend_d        = rend_q;
        frame_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (fcnt_q == len_q - ONE) begin
                    frame_start = 1'b1;
                    frame_no_d  = frame_no_q + 32'd1;
                end else begin
                    fcnt_d     = fcnt_q + ONE;
                    frame_no_d = frame_no_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_start) begin
            sync_d        = 1'b1;
            tdd_d         = tddmode;
            tstart_d      = tstart;
            tend_d        = tend;
            rstart_d      = rstart;
            rend_d        = rend;
            adj_pending_d = 1'b0;
            if (len_sum < LEN_MIN)
                len_d = LEN_MIN[CW-1:0];
            else if (len_sum > LEN_MAX)
                len_d = LEN_MAX[CW-1:0];
            else
                len_d = len_sum[CW-1:0];
        end

        // A request coinciding with a frame start is kept for the following frame.
        if (adj_req) begin
            adj_pending_d = 1'b1;
            adj_val_d     = frame_adj;
        end

        tx_hit = win_hit(tstart_d, tend_d, fcnt_d);
        rx_hit = win_hit(rstart_d, rend_d, fcnt_d);
        if (state_d == RUN) begin
            if (tdd_d) begin
                oen_d      = tx_hit;
                ien_d      = rx_hit & ~tx_hit;
                conflict_d = conflict_q | (tx_hit & rx_hit);
            end else begin
                oen_d = 1'b1;
                ien_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            len_q         <= '0;
            frame_no_q    <= '0;
            sync_q        <= 1'b0;
            ien_q         <= 1'b0;
            oen_q         <= 1'b0;
            conflict_q    <= 1'b0;
            adj_pending_q <= 1'b0;
            adj_val_q     <= '0;
            tdd_q         <= 1'b0;
            tstart_q      <= '0;
            tend_q        <= '0;
            rstart_q      <= '0;
            rend_q        <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            len_q         <= len_d;
            frame_no_q    <= frame_no_d;
            sync_q        <= sync_d;
            ien_q         <= ien_d;
            oen_q         <= oen_d;
            conflict_q    <= conflict_d;
            adj_pending_q <= adj_pending_d;
            adj_val_q     <= adj_val_d;
            tdd_q         <= tdd_d;
            tstart_q      <= tstart_d;
            tend_q        <= tend_d;
            rstart_q      <= rstart_d;
            rend_q        <= rend_d;
        end
    end

    assign ien         = ien_q;
    assign oen         = oen_q;
    assign sync        = sync_q;
    assign fcnt        = fcnt_q;
    assign frame_no    = frame_no_q;
    assign adj_pending = adj_pending_q;
    assign conflict    = conflict_q;

endmodule
